// File: rtl/seg7_scan_decoder.sv
// Receive side of a scanned seven-segment display: captures each digit once its pattern
// has been stable, decodes it back to BCD, and presents complete frames on valid/ready.
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg,
    input  logic [DIGITS-1:0]   an,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]   err_out,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                overflow
);

    localparam int                SW       = DIGITS + 7;
    localparam logic [3:0]        STABLE_C = 4'(STABLE_CYCLES);
    localparam logic [DIGITS-1:0] ALL_GOT  = '1;

    // Segment pattern {g,f,e,d,c,b,a} to {err, bcd}.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'h3F:   return {1'b0, 4'd0};
            7'h06:   return {1'b0, 4'd1};
            7'h5B:   return {1'b0, 4'd2};
            7'h4F:   return {1'b0, 4'd3};
            7'h66:   return {1'b0, 4'd4};
            7'h6D:   return {1'b0, 4'd5};
            7'h7D:   return {1'b0, 4'd6};
            7'h07:   return {1'b0, 4'd7};
            7'h7F:   return {1'b0, 4'd8};
            7'h6F:   return {1'b0, 4'd9};
            default: return 5'h1F;
        endcase
    endfunction

    logic [SW-1:0]       in_q;
    logic [SW-1:0]       sample;
    logic [3:0]          cnt_q, cnt_d;
    logic                same;
    logic                capture;
    logic                complete;
    logic                load;
    logic [4:0]          dec;
    logic [DIGITS-1:0]   got_q, got_d, got_merged;
    logic [4*DIGITS-1:0] work_bcd_q, work_bcd_d;
    logic [DIGITS-1:0]   work_err_q, work_err_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;

    // Saturating dwell counter; a capture fires only on the edge that first reaches
    // STABLE_C, so a held digit is captured exactly once no matter how long it dwells.
    always_comb begin
        sample = {an, seg};
        same   = (sample == in_q);
        if (!same) begin
            cnt_d = 4'd1;
        end else if (cnt_q >= STABLE_C) begin
            cnt_d = STABLE_C;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
        capture = $onehot(an) && (cnt_d == STABLE_C) && !(same && (cnt_q == STABLE_C));
    end

    assign dec        = decode_seg(seg);
    assign got_merged = got_q | an;
    assign complete   = capture && (got_merged == ALL_GOT);
    assign load       = complete && (!valid_q || frame_ready);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_slot
            assign work_bcd_d[4*gi +: 4] = (capture && an[gi]) ? dec[3:0] : work_bcd_q[4*gi +: 4];
            assign work_err_d[gi]        = (capture && an[gi]) ? dec[4]   : work_err_q[gi];
        end
    endgenerate

    // Frame outputs load from the next-state slots so the completing digit is included.
    always_comb begin
        got_d   = got_q;
        bcd_d   = bcd_q;
        err_d   = err_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (complete) begin
            got_d = '0;
        end else if (capture) begin
            got_d = got_merged;
        end
        if (load) begin
            bcd_d   = work_bcd_d;
            err_d   = work_err_d;
            valid_d = 1'b1;
        end else if (valid_q && frame_ready) begin
            valid_d = 1'b0;
        end
        if (complete && !load) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q       <= '0;
            cnt_q      <= '0;
            got_q      <= '0;
            work_bcd_q <= '0;
            work_err_q <= '0;
            bcd_q      <= '0;
            err_q      <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            in_q       <= sample;
            cnt_q      <= cnt_d;
            got_q      <= got_d;
            work_bcd_q <= work_bcd_d;
            work_err_q <= work_err_d;
            bcd_q      <= bcd_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign err_out     = err_q;
    assign frame_valid = valid_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: run-length reference model checked every cycle on the
// 4-digit instance, plus directed literal checks on both instances.
module tb_seg7_scan_decoder;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h00;
    logic [3:0]  an  = 4'b0000;
    logic        ready = 1'b1;
    logic [15:0] bcd_out;
    logic [3:0]  err_out;
    logic        fv, ovf;

    logic [6:0]  seg1 = 7'h00;
    logic [0:0]  an1  = 1'b0;
    logic        ready1 = 1'b1;
    logic [3:0]  bcd1;
    logic [0:0]  err1;
    logic        fv1, ovf1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .seg(seg), .an(an),
        .bcd_out(bcd_out), .err_out(err_out), .frame_valid(fv),
        .frame_ready(ready), .overflow(ovf)
    );

    seg7_scan_decoder #(.DIGITS(1), .STABLE_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst), .seg(seg1), .an(an1),
        .bcd_out(bcd1), .err_out(err1), .frame_valid(fv1),
        .frame_ready(ready1), .overflow(ovf1)
    );

    // ---------------- reference model (4 digits, S=2) ----------------
    logic [6:0]  pat_tbl [0:9];
    logic [10:0] m_prev;
    int          m_run;
    logic [3:0]  m_got;
    logic [3:0]  m_wb [0:3];
    logic [3:0]  m_we;
    logic [15:0] m_bcd;
    logic [3:0]  m_err;
    logic        m_fv, m_ovf;
    logic        m_live = 1'b0;

    initial begin
        pat_tbl[0] = 7'h3F; pat_tbl[1] = 7'h06; pat_tbl[2] = 7'h5B; pat_tbl[3] = 7'h4F;
        pat_tbl[4] = 7'h66; pat_tbl[5] = 7'h6D; pat_tbl[6] = 7'h7D; pat_tbl[7] = 7'h07;
        pat_tbl[8] = 7'h7F; pat_tbl[9] = 7'h6F;
    end

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int i = 0; i < 10; i++)
            if (s == pat_tbl[i]) return {1'b0, 4'(i)};
        return 5'h1F;
    endfunction

    always @(posedge clk) begin
        logic [10:0] cur;
        logic [4:0]  d;
        logic        done;
        int          idx;
        if (rst) begin
            m_prev = '0; m_run = 0; m_got = '0; m_we = '0;
            for (int i = 0; i < 4; i++) m_wb[i] = '0;
            m_bcd = '0; m_err = '0; m_fv = 1'b0; m_ovf = 1'b0;
            m_live = 1'b1;
        end else begin
            cur = {an, seg};
            if (cur == m_prev) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 1;
            end
            m_prev = cur;
            done = 1'b0;
            if (m_run == S && $countones(an) == 1) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (an[i]) idx = i;
                d = ref_decode(seg);
                m_wb[idx] = d[3:0];
                m_we[idx] = d[4];
                m_got[idx] = 1'b1;
                if (m_got == 4'hF) begin
                    m_got = '0;
                    done = 1'b1;
                    if (!m_fv || ready) begin
                        for (int i = 0; i < 4; i++) m_bcd[4*i +: 4] = m_wb[i];
                        m_err = m_we;
                        m_fv = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            if (!done && m_fv && ready) m_fv = 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_live) begin
            tests++;
            if (bcd_out !== m_bcd || err_out !== m_err || fv !== m_fv || ovf !== m_ovf) begin
                fails++;
                $display("FAIL model t=%0t: bcd=%h err=%b fv=%b ovf=%b, required bcd=%h err=%b fv=%b ovf=%b",
                         $time, bcd_out, err_out, fv, ovf, m_bcd, m_err, m_fv, m_ovf);
            end
        end
    end

    // Frame monitor for directed checks.
    int          fv_cycles = 0;
    int          fv1_cycles = 0;
    logic [15:0] last_bcd = '0;
    logic [3:0]  last_err = '0;
    logic [3:0]  last_bcd1 = '0;
    logic        last_err1 = 1'b0;

    always @(negedge clk) begin
        if (fv === 1'b1) begin fv_cycles++; last_bcd = bcd_out; last_err = err_out; end
        if (fv1 === 1'b1) begin fv1_cycles++; last_bcd1 = bcd1; last_err1 = err1[0]; end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        tick(n);
    endtask

    task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        drive(4'b0001, s0, 3);
        drive(4'b0010, s1, 3);
        drive(4'b0100, s2, 3);
        drive(4'b1000, s3, 3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tick(3);
        check("reset_bcd", 32'(bcd_out), 32'h0);
        check("reset_err_fv_ovf", {27'b0, err_out, fv, ovf}, 32'h0);
        rst = 1'b0;
        tick(2);

        // Scan 3,4,5,6 with ready high; watch the frame timing on digit 3.
        fv_cycles = 0;
        drive(4'b0001, 7'h4F, 3);
        drive(4'b0010, 7'h66, 3);
        drive(4'b0100, 7'h6D, 3);
        an = 4'b1000; seg = 7'h7D;
        tick(1);
        check("scan_fv_after_1st_edge", 32'(fv), 32'h0);
        tick(1);
        check("scan_fv_after_2nd_edge", 32'(fv), 32'h1);
        check("scan_bcd", 32'(bcd_out), 32'h6543);
        check("scan_err", 32'(err_out), 32'h0);
        tick(1);
        check("scan_fv_drops", 32'(fv), 32'h0);
        drive(4'b0000, 7'h00, 2);
        check("scan_fv_cycles", fv_cycles, 1);

        // Illegal pattern on digit 2.
        fv_cycles = 0;
        scan4(7'h4F, 7'h66, 7'h00, 7'h7D);
        drive(4'b0000, 7'h00, 2);
        check("illegal_fv_cycles", fv_cycles, 1);
        check("illegal_bcd", 32'(last_bcd), 32'h6F43);
        check("illegal_err", 32'(last_err), 32'h4);

        // Stability filter on the 1-digit, 3-sample instance.
        fv1_cycles = 0;
        an1 = 1'b1; seg1 = 7'h06;
        tick(2);
        seg1 = 7'h5B;
        tick(3);
        an1 = 1'b0; seg1 = 7'h00;
        tick(3);
        check("filter_captures", fv1_cycles, 1);
        check("filter_bcd", 32'(last_bcd1), 32'h2);
        check("filter_err", 32'(last_err1), 32'h0);

        // Glitch on the 4-digit instance: one-sample glitch inside digit 0's dwell.
        fv_cycles = 0;
        drive(4'b0001, 7'h06, 1);
        drive(4'b0001, 7'h7F, 1);
        drive(4'b0001, 7'h06, 3);
        drive(4'b0010, 7'h5B, 3);
        drive(4'b0100, 7'h4F, 3);
        drive(4'b1000, 7'h66, 3);
        drive(4'b0000, 7'h00, 2);
        check("glitch_fv_cycles", fv_cycles, 1);
        check("glitch_bcd", 32'(last_bcd), 32'h4321);

        // Invalid enables never capture.
        fv_cycles = 0;
        drive(4'b0000, 7'h4F, 10);
        drive(4'b0011, 7'h4F, 10);
        drive(4'b0000, 7'h00, 2);
        check("bad_an_fv_cycles", fv_cycles, 0);

        // Backpressure: two frames with ready low, second one dropped.
        ready = 1'b0;
        scan4(7'h06, 7'h5B, 7'h4F, 7'h66);
        scan4(7'h6D, 7'h7D, 7'h07, 7'h7F);
        drive(4'b0000, 7'h00, 1);
        check("bp_bcd_held", 32'(bcd_out), 32'h4321);
        check("bp_fv", 32'(fv), 32'h1);
        check("bp_overflow", 32'(ovf), 32'h1);
        ready = 1'b1;
        tick(1);
        check("bp_fv_after_accept", 32'(fv), 32'h0);
        check("bp_bcd_after_accept", 32'(bcd_out), 32'h4321);
        check("bp_overflow_sticky", 32'(ovf), 32'h1);

        // Reset mid-frame, with digit 2 straddling the release.
        drive(4'b0001, 7'h7F, 3);
        drive(4'b0010, 7'h6F, 3);
        rst = 1'b1; an = 4'b0100; seg = 7'h07;
        tick(1);
        check("rst_outputs", {11'b0, bcd_out, err_out, fv, ovf}, 32'h0);
        tick(1);
        rst = 1'b0;
        fv_cycles = 0;
        tick(3);
        drive(4'b1000, 7'h5B, 3);
        drive(4'b0001, 7'h3F, 3);
        drive(4'b0010, 7'h06, 3);
        drive(4'b0000, 7'h00, 2);
        check("rst_fv_cycles", fv_cycles, 1);
        check("rst_frame_bcd", 32'(last_bcd), 32'h2710);
        check("rst_ovf_cleared", 32'(ovf), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Recovers packed BCD digits from a multiplexed, active-high seven-segment display bus. It is the receive-side counterpart of the BCD-to-seven-segment decoder: a scanned display driver feeds it `seg`/`an`. Each digit is captured once its pattern has been stable, decoded back to BCD and flagged if the pattern is illegal. Complete multi-digit frames are presented on a valid/ready output.

## Interface
- `DIGITS`, 4, number of multiplexed digits (1..8).
- `STABLE_CYCLES`, 2, consecutive identical samples required before a digit is captured (1..15).

- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `seg` input 7: segment pattern `{g,f,e,d,c,b,a}`, active-high.
- `an` input DIGITS: digit enable, active-high; must be one-hot for a legal sample; bit i selects digit i.
- `bcd_out` output 4*DIGITS: frame digits; digit i at `[4i+3:4i]`.
- `err_out` output DIGITS: bit i set when digit i's pattern was illegal.
- `frame_valid` output 1: frame available; held until accepted.
- `frame_ready` input 1: consumer accepts the frame when `frame_valid && frame_ready` on a rising edge.
- `overflow` output 1: sticky; a completed frame was dropped.

## Operation
- Legal patterns (hex, gfedcba) map to BCD as follows:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4
  - 6D→5, 7D→6, 07→7, 7F→8, 6F→9
  - any other pattern decodes to 4'hF with the error bit set.
- Sample register `in_q` and counter `cnt` are updated at every edge:
  - if `{an,seg} == in_q`, then `cnt <= min(cnt+1, STABLE_CYCLES)`;
  - otherwise `cnt <= 1`;
  - in both cases `in_q <= {an,seg}`.
- Capture happens at the edge where the new `cnt` first equals `STABLE_CYCLES` and `an` is one-hot.
  - Saturation guarantees exactly one capture per dwell.
  - `an` zero or multi-hot never captures, though it still runs the counter.
- On capture of digit i:
  - the decoded BCD and error bit go into working slot i;
  - `got[i]` is set;
  - re-capturing a digit before the frame completes overwrites its slot.
- Frame completion happens at the capture edge where `got` would become all-ones. At that edge `got` clears to 0.
  - If `frame_valid` is low, or is being accepted at the same edge: working slots, including the one just captured, load into `bcd_out`/`err_out` and `frame_valid` is 1.
  - Otherwise the frame is discarded and `overflow` is set to 1. It stays set until `rst`.
- Acceptance without a new completion: `frame_valid` falls to 0 and `bcd_out`/`err_out` hold their last values.
- Outputs are stable while `frame_valid` is high. They change only at a loading edge.
- Digit order within a frame is irrelevant; any scan order completes it.

## Timing
- Reset values: `in_q`=0, `cnt`=0, `got`=0, working slots=0, `bcd_out`=0, `err_out`=0, `frame_valid`=0, `overflow`=0.
- Capture latency: an input first sampled at edge k and held is captured at edge k+STABLE_CYCLES-1. With the default of 2, capture is at edge k+1.
- Frame latency: `frame_valid` is high in the cycle following the completing capture edge. There is no extra pipeline stage.
- Back-to-back frames: accept and complete at the same edge → the new frame loads and `frame_valid` stays 1.
- Reset mid-frame or with a pending frame drops everything. A dwell straddling the reset release restarts its count from 1.
- Glitch shorter than `STABLE_CYCLES` samples: ignored. The original value, once restored, restarts its count at 1.

## Test plan
- Scan with DIGITS=4, STABLE_CYCLES=2 and `frame_ready`=1: drive `an`=0001/0010/0100/1000 with `seg`=4F/66/6D/7D, 3 cycles each. Required: `bcd_out`=16'h6543, `err_out`=0, `frame_valid` high for 1 cycle, one cycle after the 2nd edge of digit 3.
- Illegal pattern: as above but digit 2 has `seg`=7'h00. Required: `bcd_out`=16'h6F43, `err_out`=4'b0100.
- Stability filter with STABLE_CYCLES=3: digit 0 driven with `seg`=06 for 2 cycles, then 5B for 3 cycles. Required: digit 0 reads 2, and exactly one capture occurs.
- Invalid enables: `an`=0000 and `an`=0011 held for 10 cycles. Required: no capture and `frame_valid` stays 0.
- Backpressure: `frame_ready`=0, scan two full frames (123 4, then 5678). Required: `bcd_out` holds 16'h4321 and `overflow`=1. Then assert `frame_ready`: `frame_valid`→0 next edge.
- Reset: assert `rst` after 2 digits, then scan a full frame. Required: all outputs are 0 during reset, and the first frame contains only post-reset captures.
